// File: rtl/display_pkg.sv
// Shared types and segment constants for the multiplexed seven-segment scanner.
// Segment order is {a,b,c,d,e,f,g}, active-low.
package display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_DIG_0 = 7'b0000001;
  localparam seg7_t SEG_DIG_1 = 7'b1001111;
  localparam seg7_t SEG_DIG_2 = 7'b0010010;
  localparam seg7_t SEG_DIG_3 = 7'b0000110;
  localparam seg7_t SEG_DIG_4 = 7'b1001100;
  localparam seg7_t SEG_DIG_5 = 7'b0100100;
  localparam seg7_t SEG_DIG_6 = 7'b0100000;
  localparam seg7_t SEG_DIG_7 = 7'b0001111;
  localparam seg7_t SEG_DIG_8 = 7'b0000000;
  localparam seg7_t SEG_DIG_9 = 7'b0000100;
  localparam seg7_t SEG_DIG_A = 7'b0001000;
  localparam seg7_t SEG_DIG_B = 7'b1100000;
  localparam seg7_t SEG_DIG_C = 7'b0110001;
  localparam seg7_t SEG_DIG_D = 7'b1000010;
  localparam seg7_t SEG_DIG_E = 7'b0110000;
  localparam seg7_t SEG_DIG_F = 7'b0111000;

  // Anode dead time inserted after every digit change.
  localparam int unsigned DEAD_CYCLES = 1;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to active-low seven-segment pattern.
// Define DISP_HEX_EN to show A-F for values 10-15; otherwise they stay blank.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] value_i,
  output seg7_t      seg_o
);

  // Value lookup; anything without a glyph falls through to blank.
  always_comb begin
    seg_o = SEG_BLANK;
    case (value_i)
      4'd0:    seg_o = SEG_DIG_0;
      4'd1:    seg_o = SEG_DIG_1;
      4'd2:    seg_o = SEG_DIG_2;
      4'd3:    seg_o = SEG_DIG_3;
      4'd4:    seg_o = SEG_DIG_4;
      4'd5:    seg_o = SEG_DIG_5;
      4'd6:    seg_o = SEG_DIG_6;
      4'd7:    seg_o = SEG_DIG_7;
      4'd8:    seg_o = SEG_DIG_8;
      4'd9:    seg_o = SEG_DIG_9;
`ifdef DISP_HEX_EN
      4'd10:   seg_o = SEG_DIG_A;
      4'd11:   seg_o = SEG_DIG_B;
      4'd12:   seg_o = SEG_DIG_C;
      4'd13:   seg_o = SEG_DIG_D;
      4'd14:   seg_o = SEG_DIG_E;
      4'd15:   seg_o = SEG_DIG_F;
`endif
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed common-anode seven-segment scanner with shadowed data,
// leading-zero suppression, blank mask and decimal points. Hex glyphs: DISP_HEX_EN.
module display_scan
  import display_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   an_out
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam bit HAS_DEAD = (N_DIGITS > 1) && (DEAD_CYCLES > 0);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   digits_q, digits_d;
  logic [N_DIGITS-1:0]     dp_q, dp_d;
  logic [N_DIGITS-1:0]     blank_q, blank_d;
  seg7_t                   seg_q, seg_d;
  logic                    dpo_q, dpo_d;
  logic [N_DIGITS-1:0]     an_q, an_d;

  logic                    tick_s;
  logic                    dead_s;
  logic                    dark_s;
  logic [N_DIGITS-1:0]     lz_mask_s;
  logic [3:0]              sel_nib_s;
  seg7_t                   dec_seg_s;

  assign tick_s    = (presc_q == PW'(SCAN_DIV - 1));
  assign dead_s    = tick_s & HAS_DEAD;
  assign sel_nib_s = digits_q[4*int'(idx_q) +: 4];

  seg7_decode u_dec (
    .value_i (sel_nib_s),
    .seg_o   (dec_seg_s)
  );

  // Prescaler, digit index and shadow register next state.
  always_comb begin
    presc_d  = presc_q + PW'(1);
    idx_d    = idx_q;
    digits_d = digits_q;
    dp_d     = dp_q;
    blank_d  = blank_q;
    if (tick_s) begin
      presc_d = {PW{1'b0}};
      if (idx_q == IW'(N_DIGITS - 1)) begin
        idx_d = {IW{1'b0}};
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      idx_d = idx_q;
    end
    if (load) begin
      digits_d = digits_in;
      dp_d     = dp_in;
      blank_d  = blank_in;
    end else begin
      digits_d = digits_q;
    end
  end

  // A digit is a leading zero when it and everything above it are zero; digit 0 never is.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    lz_mask_s = {N_DIGITS{1'b0}};
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (digits_q[4*i +: 4] == 4'h0);
      lz_mask_s[i] = zero_run & (i != 0);
    end
  end

  assign dark_s = blank_q[idx_q] | (lz_en & lz_mask_s[idx_q]);

  // Output register next state; the tick cycle becomes the anti-ghost gap.
  always_comb begin
    seg_d = SEG_BLANK;
    dpo_d = 1'b1;
    an_d  = {N_DIGITS{1'b1}};
    if (!dead_s) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        an_d[i] = (i != int'(idx_q));
      end
      if (!dark_s) begin
        seg_d = dec_seg_s;
        dpo_d = ~dp_q[idx_q];
      end else begin
        seg_d = SEG_BLANK;
        dpo_d = 1'b1;
      end
    end else begin
      an_d = {N_DIGITS{1'b1}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= {PW{1'b0}};
      idx_q    <= {IW{1'b0}};
      digits_q <= {(4*N_DIGITS){1'b0}};
      dp_q     <= {N_DIGITS{1'b0}};
      blank_q  <= {N_DIGITS{1'b1}};
      seg_q    <= SEG_BLANK;
      dpo_q    <= 1'b1;
      an_q     <= {N_DIGITS{1'b1}};
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      digits_q <= digits_d;
      dp_q     <= dp_d;
      blank_q  <= blank_d;
      seg_q    <= seg_d;
      dpo_q    <= dpo_d;
      an_q     <= an_d;
    end
  end

  assign seg_out = seg_q;
  assign dp_out  = dpo_q;
  assign an_out  = an_q;

endmodule

// File: tb/tb_display_scan.sv
// Randomized bench for display_scan (N_DIGITS=4, SCAN_DIV=4) against a cycle-count
// reference model; expected glyphs for 10-15 follow DISP_HEX_EN.
module tb_display_scan;

  localparam int ND = 4;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   digits_in;
  logic [3:0]    dp_in;
  logic [3:0]    blank_in;
  logic          lz_en;
  logic          load;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic [3:0]    an_out;

  display_scan #(.N_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .blank_in  (blank_in),
    .lz_en     (lz_en),
    .load      (load),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .an_out    (an_out)
  );

  always #5 clk = ~clk;

  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         k;
  int         m_dig [ND];
  bit         m_dp [ND];
  bit         m_blank [ND];
  logic [6:0] seg_tab [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int j = 0; j < ND; j++) begin
      m_dig[j]   = 0;
      m_dp[j]    = 1'b0;
      m_blank[j] = 1'b1;
    end
  endtask

  // Expected {an,dp,seg} right after the kk-th clock edge since reset release.
  function automatic logic [11:0] expect_out(input int kk, input bit lz);
    int         pos;
    bit         zero_above;
    bit         dark;
    logic [3:0] an;
    if (kk % SD == 0) return {4'b1111, 1'b1, 7'b1111111};
    pos = ((kk - 1) / SD) % ND;
    zero_above = 1'b1;
    for (int j = pos; j < ND; j++) if (m_dig[j] != 0) zero_above = 1'b0;
    dark = m_blank[pos] || (lz && pos != 0 && zero_above);
    an = 4'b1111;
    an[pos] = 1'b0;
    if (dark) return {an, 1'b1, 7'b1111111};
    return {an, ~m_dp[pos], seg_tab[m_dig[pos]]};
  endfunction

  task automatic step();
    logic [11:0] e;
    e = expect_out(k + 1, lz_en);
    @(posedge clk);
    #1;
    k++;
    chk("scan", {20'h0, an_out, dp_out, seg_out}, {20'h0, e});
    if (load) begin
      for (int j = 0; j < ND; j++) begin
        m_dig[j]   = int'(digits_in[4*j +: 4]);
        m_dp[j]    = dp_in[j];
        m_blank[j] = blank_in[j];
      end
    end
    load = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    digits_in = d;
    dp_in     = dp;
    blank_in  = bl;
    load      = 1'b1;
    step();
  endtask

  initial begin
    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
    seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
    seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
`ifdef DISP_HEX_EN
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
    seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
    seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;
`else
    for (int j = 10; j < 16; j++) seg_tab[j] = 7'b1111111;
`endif
    rst_n = 1'b1; digits_in = 16'h0; dp_in = 4'h0; blank_in = 4'h0;
    lz_en = 1'b0; load = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #2 chk("rst_async", {20'h0, an_out, dp_out, seg_out}, 32'h0000_0FFF);
    repeat (3) @(posedge clk);
    #1 chk("rst_hold", {20'h0, an_out, dp_out, seg_out}, 32'h0000_0FFF);
    rst_n = 1'b1;
    model_reset();

    run(40);
    do_load(16'h1234, 4'h0, 4'h0); run(20);
    lz_en = 1'b1;
    do_load(16'h0070, 4'b0100, 4'h0); run(20);
    do_load(16'h00AF, 4'h0, 4'h0); run(20);
    do_load(16'h0000, 4'h0, 4'h0); run(16);
    do_load(16'h0305, 4'h0, 4'b0100); run(16);
    lz_en = 1'b0;
    do_load(16'h0000, 4'h0, 4'h0);
    while ((k + 1) % SD != 0) step();
    do_load(16'h9999, 4'h0, 4'h0); run(8);

    repeat (600) begin
      if ($urandom % 6 == 0) begin
        for (int j = 0; j < ND; j++)
          digits_in[4*j +: 4] = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom % 16);
        dp_in    = 4'($urandom % 16);
        blank_in = ($urandom % 4 == 0) ? 4'($urandom % 16) : 4'h0;
        load     = 1'b1;
      end
      if ($urandom % 16 == 0) lz_en = ~lz_en;
      step();
    end

    while (k % SD != 2) step();
    #3 rst_n = 1'b0;
    #1 chk("rst_mid", {20'h0, an_out, dp_out, seg_out}, 32'h0000_0FFF);
    repeat (3) @(posedge clk);
    #1 chk("rst_mid_hold", {20'h0, an_out, dp_out, seg_out}, 32'h0000_0FFF);
    rst_n = 1'b1;
    model_reset();
    run(20);
    do_load(16'h5678, 4'b1010, 4'h0); run(20);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
